rtlinf_iter_scheduler: RTL and testbench
========================================

RTLINF_ITER_SCHEDULER -- requirements
Module: rtlinf_iter_scheduler

Interface
REQ-001 SHALL have parameter LOG_MAX_ITERS, default 8, giving the iteration counter width.
REQ-002 SHALL have parameter LOG_MAX_READS_PER_ITER, default 8, giving the per-iteration read counter width.
REQ-003 SHALL have parameter LOG_MAX_ADDRESS, default 12, giving the BRAM address width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port configure  in  1  start pulse; params sampled on same edge.
REQ-007 SHALL have port num_iters  in  LOG_MAX_ITERS  iterations per run.
REQ-008 SHALL have port num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  reads per iteration.
REQ-009 SHALL have port read_address  in  LOG_MAX_ADDRESS  first read address.
REQ-010 SHALL have port write_address  in  LOG_MAX_ADDRESS  first write address.
REQ-011 SHALL have port rd_addr  out  LOG_MAX_ADDRESS  current read address.
REQ-012 SHALL have port rd_valid  out  1  read request valid.
REQ-013 SHALL have port rd_ready  in  1  downstream accepts read.
REQ-014 SHALL have port rd_last  out  1  current read is last of its iteration.
REQ-015 SHALL have port res_valid  in  1  datapath produced one iteration result.
REQ-016 SHALL have port wr_en  out  1  write strobe (combinational from res_valid).
REQ-017 SHALL have port wr_addr  out  LOG_MAX_ADDRESS  current write address.
REQ-018 SHALL have port busy  out  1  run in progress.
REQ-019 SHALL have port done  out  1  one-cycle end-of-run pulse.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN only.
REQ-021 IDLE: configure=1 SHALL latch all four params, clear read/iter/write counters, go to RUN next cycle.
REQ-022 configure SHALL be ignored in RUN, DRAIN, DONE (no relatch, no restart).
REQ-023 configure with num_iters=0 or num_reads_per_iter=0 SHALL go IDLE->DONE directly, no reads/writes issued.
REQ-024 RUN: rd_valid=1; rd_addr = latched read_address + total accepted reads, modulo 2^LOG_MAX_ADDRESS (wraps silently).
REQ-025 Read accepted when rd_valid & rd_ready; only then SHALL rd_addr/counters advance; rd_addr SHALL hold stable while rd_valid & !rd_ready.
REQ-026 rd_last SHALL be 1 when rd_valid and per-iteration read count = num_reads_per_iter-1; on acceptance per-iteration count clears, iteration count increments.
REQ-027 Acceptance of read num_iters*num_reads_per_iter SHALL move RUN->DRAIN (rd_valid=0 from next cycle).
REQ-028 wr_en = res_valid & busy & (write count < num_iters); wr_addr = latched write_address + write count, modulo 2^LOG_MAX_ADDRESS; write count increments on wr_en.
REQ-029 res_valid SHALL be accepted in RUN as well as DRAIN; ignored in IDLE/DONE and when write count = num_iters.
REQ-030 DRAIN SHALL go to DONE on the edge where write count reaches num_iters; if last read acceptance and last write coincide in RUN, RUN->DONE directly.
REQ-031 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-032 Latency: configure edge to first rd_valid SHALL be 1 cycle; last write edge to done SHALL be 1 cycle.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, clear all counters and latched params; rd_valid, rd_last, busy, done = 0, rd_addr, wr_addr = 0; wr_en = 0 while rst=1.
REQ-034 rst asserted mid-run SHALL abort the run with no done pulse; after release block SHALL accept a new configure.

Verification
REQ-035 iters=2, reads=4, read_address=0x010, write_address=0x100, rd_ready=1 -> rd_addr 0x010..0x017, rd_last on 0x013 and 0x017, wr_addr 0x100,0x101, one done.
REQ-036 Same config, rd_ready toggled 1/0 each cycle -> rd_addr held across stall cycles, exactly 8 accepts, no duplicated/skipped address.
REQ-037 read_address=0xFFE, iters=1, reads=4 -> rd_addr 0xFFE,0xFFF,0x000,0x001.
REQ-038 iters=0 -> done one cycle after configure, busy never 1, rd_valid never 1.
REQ-039 configure pulsed again mid-RUN with different params -> ignored, original sequence completes; extra res_valid after num_iters writes -> no wr_en.
REQ-040 rst pulsed after 3 accepted reads -> all outputs 0 immediately, no done; new configure then runs from its own read_address.

Source files
------------

// File: rtl/rtlinf_iter_scheduler_if.sv
// Bundle of the scheduler's configuration, read-request, write-strobe and
// status signals. The scheduler itself connects through the slave modport.
// The block that configures it and feeds it handshakes uses the master modport.
interface rtlinf_iter_scheduler_if #(
  parameter int LOG_MAX_ITERS          = 8,
  parameter int LOG_MAX_READS_PER_ITER = 8,
  parameter int LOG_MAX_ADDRESS        = 12
);
  logic                              configure;
  logic [LOG_MAX_ITERS-1:0]          num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]        read_address;
  logic [LOG_MAX_ADDRESS-1:0]        write_address;
  logic [LOG_MAX_ADDRESS-1:0]        rd_addr;
  logic                              rd_valid;
  logic                              rd_ready;
  logic                              rd_last;
  logic                              res_valid;
  logic                              wr_en;
  logic [LOG_MAX_ADDRESS-1:0]        wr_addr;
  logic                              busy;
  logic                              done;

  modport master (
    output configure, num_iters, num_reads_per_iter, read_address, write_address,
    output rd_ready, res_valid,
    input  rd_addr, rd_valid, rd_last, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  configure, num_iters, num_reads_per_iter, read_address, write_address,
    input  rd_ready, res_valid,
    output rd_addr, rd_valid, rd_last, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/rtlinf_iter_scheduler.sv
// Iteration scheduler: streams num_iters * num_reads_per_iter consecutive
// read addresses (with a per-iteration last flag), and hands out one write
// address per iteration result until num_iters results have been stored.
module rtlinf_iter_scheduler #(
  parameter int LOG_MAX_ITERS          = 8,
  parameter int LOG_MAX_READS_PER_ITER = 8,
  parameter int LOG_MAX_ADDRESS        = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  rtlinf_iter_scheduler_if.slave bus
);

  localparam int IW = LOG_MAX_ITERS;
  localparam int RW = LOG_MAX_READS_PER_ITER;
  localparam int AW = LOG_MAX_ADDRESS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] I_ONE = IW'(1);
  localparam logic [RW-1:0] R_ONE = RW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] iters_q, iters_d;        // latched num_iters
  logic [RW-1:0] reads_q, reads_d;        // latched num_reads_per_iter
  logic [AW-1:0] rd_base_q, rd_base_d;    // latched read_address
  logic [AW-1:0] wr_base_q, wr_base_d;    // latched write_address
  logic [AW-1:0] rd_acc_q, rd_acc_d;      // total accepted reads, mod 2^AW
  logic [RW-1:0] rcnt_q, rcnt_d;          // reads accepted in current iteration
  logic [IW-1:0] iter_cnt_q, iter_cnt_d;  // completed read iterations
  logic [IW-1:0] wr_cnt_q, wr_cnt_d;      // results written

  logic busy, rd_valid, rd_last, rd_accept, last_iter, final_read;
  logic wr_en, wr_final, writes_complete, zero_cfg;

  // Output decode and handshake qualifiers derived from current state.
  always_comb begin
    busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
    rd_valid        = (state_q == S_RUN);
    rd_last         = rd_valid && (rcnt_q == reads_q - R_ONE);
    rd_accept       = rd_valid && bus.rd_ready;
    last_iter       = (iter_cnt_q == iters_q - I_ONE);
    final_read      = rd_accept && rd_last && last_iter;
    wr_en           = bus.res_valid && busy && (wr_cnt_q < iters_q);
    wr_final        = wr_en && (wr_cnt_q == iters_q - I_ONE);
    // All results stored, either already or by the write happening this cycle.
    writes_complete = wr_final || (wr_cnt_q == iters_q);
    zero_cfg        = (bus.num_iters == '0) || (bus.num_reads_per_iter == '0);
  end

  assign bus.busy     = busy;
  assign bus.done     = (state_q == S_DONE);
  assign bus.rd_valid = rd_valid;
  assign bus.rd_last  = rd_last;
  assign bus.rd_addr  = rd_base_q + rd_acc_q;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_base_q + AW'(wr_cnt_q);

  // Next-state logic for the run FSM and all counters.
  always_comb begin
    state_d    = state_q;
    iters_d    = iters_q;
    reads_d    = reads_q;
    rd_base_d  = rd_base_q;
    wr_base_d  = wr_base_q;
    rd_acc_d   = rd_acc_q;
    rcnt_d     = rcnt_q;
    iter_cnt_d = iter_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    if (rd_accept) begin
      rd_acc_d = rd_acc_q + A_ONE;
      if (rd_last) begin
        rcnt_d     = '0;
        iter_cnt_d = iter_cnt_q + I_ONE;
      end else begin
        rcnt_d = rcnt_q + R_ONE;
      end
    end
    if (wr_en) wr_cnt_d = wr_cnt_q + I_ONE;

    case (state_q)
      S_IDLE: begin
        if (bus.configure) begin
          iters_d    = bus.num_iters;
          reads_d    = bus.num_reads_per_iter;
          rd_base_d  = bus.read_address;
          wr_base_d  = bus.write_address;
          rd_acc_d   = '0;
          rcnt_d     = '0;
          iter_cnt_d = '0;
          wr_cnt_d   = '0;
          state_d    = zero_cfg ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Results may finish before the reads do; then the last read ends the run.
        if (final_read) state_d = writes_complete ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_final) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iters_q    <= '0;
      reads_q    <= '0;
      rd_base_q  <= '0;
      wr_base_q  <= '0;
      rd_acc_q   <= '0;
      rcnt_q     <= '0;
      iter_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      iters_q    <= iters_d;
      reads_q    <= reads_d;
      rd_base_q  <= rd_base_d;
      wr_base_q  <= wr_base_d;
      rd_acc_q   <= rd_acc_d;
      rcnt_q     <= rcnt_d;
      iter_cnt_q <= iter_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_rtlinf_iter_scheduler.sv
// Self-checking bench for rtlinf_iter_scheduler. A run-level reference model
// (phase, accepted reads, written results) predicts every output each cycle.
module tb_rtlinf_iter_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtlinf_iter_scheduler_if #(.LOG_MAX_ITERS(8), .LOG_MAX_READS_PER_ITER(8),
                             .LOG_MAX_ADDRESS(12)) bus ();

  rtlinf_iter_scheduler #(.LOG_MAX_ITERS(8), .LOG_MAX_READS_PER_ITER(8),
                          .LOG_MAX_ADDRESS(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = run in progress, 2 = done pulse.
  int m_phase = 0;
  int m_acc = 0, m_wrs = 0, m_I = 0, m_R = 0, m_rb = 0, m_wb = 0;
  int run_dones = 0, run_accs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic cfg, input int I, input int R, input int ra, input int wa,
                      input logic rdy, input logic rv);
    logic exp_valid, exp_wr;
    @(negedge clk);
    bus.configure          = cfg;
    bus.num_iters          = I[7:0];
    bus.num_reads_per_iter = R[7:0];
    bus.read_address       = ra[11:0];
    bus.write_address      = wa[11:0];
    bus.rd_ready           = rdy;
    bus.res_valid          = rv;
    #1;
    exp_valid = (m_phase == 1) && (m_acc < m_I * m_R);
    exp_wr    = rv && (m_phase == 1) && (m_wrs < m_I);
    chk("busy", bus.busy, (m_phase == 1));
    chk("done", bus.done, (m_phase == 2));
    chk("rd_valid", bus.rd_valid, exp_valid);
    chk("wr_en", bus.wr_en, exp_wr);
    if (exp_valid) begin
      chk("rd_addr", bus.rd_addr, (m_rb + m_acc) % 4096);
      chk("rd_last", bus.rd_last, ((m_acc % m_R) == m_R - 1));
    end
    if (exp_wr) chk("wr_addr", bus.wr_addr, (m_wb + m_wrs) % 4096);
    if (bus.done) run_dones++;
    if (bus.rd_valid && rdy) run_accs++;
    $display("t=%0t cfg=%0b rdy=%0b rv=%0b rd_valid=%0b rd_addr=%03h last=%0b wr_en=%0b wr_addr=%03h busy=%0b done=%0b",
             $time, cfg, rdy, rv, bus.rd_valid, bus.rd_addr, bus.rd_last, bus.wr_en,
             bus.wr_addr, bus.busy, bus.done);
    case (m_phase)
      0: if (cfg) begin
           m_I = I % 256; m_R = R % 256; m_rb = ra % 4096; m_wb = wa % 4096;
           m_acc = 0; m_wrs = 0;
           m_phase = (m_I == 0 || m_R == 0) ? 2 : 1;
         end
      1: begin
           if (exp_valid && rdy) m_acc++;
           if (exp_wr) m_wrs++;
           if (m_acc == m_I * m_R && m_wrs == m_I) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  // Configure one run and drive it to completion.
  // mode 0: rd_ready always 1; mode 1: toggling 1/0; mode 2: random.
  task automatic run_cfg(input int I, input int R, input int ra, input int wa,
                         input int mode, input bit reconf);
    int steps;
    logic rdy, rv, cfg;
    run_dones = 0;
    run_accs  = 0;
    step(1'b1, I, R, ra, wa, 1'b1, 1'b0);
    steps = 0;
    while (m_phase != 0 && steps < 400) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((steps % 2) == 0) : 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      cfg = reconf && (steps == 2);
      step(cfg, I + 1, R + 2, ra ^ 'h555, wa + 7, rdy, rv);
      steps++;
    end
    if (steps >= 400) begin
      checks++;
      failures++;
      $error("FAIL timeout observed=%0d expected_below=400", steps);
    end
    // Extra results after the run must produce no write strobe.
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    chk("done_count", run_dones, 1);
    chk("accepts", run_accs, (I == 0 || R == 0) ? 0 : I * R);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_last"}, bus.rd_last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
  endtask

  initial begin
    bus.configure = 1'b0; bus.num_iters = '0; bus.num_reads_per_iter = '0;
    bus.read_address = '0; bus.write_address = '0;
    bus.rd_ready = 1'b0; bus.res_valid = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    bus.res_valid = 1'b0;

    // Basic run, stalled run, address wrap, zero-length runs.
    run_cfg(2, 4, 'h010, 'h100, 0, 1'b0);
    run_cfg(2, 4, 'h010, 'h100, 1, 1'b0);
    run_cfg(1, 4, 'hFFE, 'hFFF, 0, 1'b0);
    run_cfg(0, 4, 'h123, 'h456, 0, 1'b0);
    run_cfg(3, 0, 'h123, 'h456, 2, 1'b0);
    // Configure again mid-run: must be ignored.
    run_cfg(2, 3, 'h040, 'h080, 2, 1'b1);

    // Reset after three accepted reads aborts the run with no done pulse.
    run_dones = 0;
    step(1'b1, 2, 4, 'h020, 'h200, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.res_valid = 1'b1;
    m_phase = 0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    chk("midrst_no_done", run_dones, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cfg(1, 3, 'h300, 'h050, 0, 1'b0);

    // Randomized runs.
    for (int n = 0; n < 10; n++) begin
      run_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
